pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed 32-bit, single-stage, free-running pipeline register.
- Carries a WIDTH-bit payload through DEPTH register stages using a valid/ready handshake.
- Bubbles collapse, backpressure is supported, and a synchronous flush clears the chain.
- Sits between ALU sub-units (e.g. adder output to writeback) wherever a retimed, stallable boundary is needed.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 2, number of register stages (>=1; 1 is legal).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stages.
- in_valid  input  1  upstream beat present.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  chain accepts beat this cycle.
- out_valid  output  1  beat present at last stage.
- out_data  output  WIDTH  payload of last stage.
- out_ready  input  1  downstream accepts beat.
- occ  output  $clog2(DEPTH+1)  occupancy; present only with PIPE_OCC_EN.

Behaviour:
- Per stage i (0..DEPTH-1) the chain holds vld_q[i] and dat_q[i].
- Ready chain:
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !vld_q[i] || rdy[i+1], computed combinationally.
  - in_ready = rdy[0] && !flush.
- Stage source: in_valid/in_data for stage 0; vld_q[i-1]/dat_q[i-1] for stage i>0.
- On each rising clk edge, when rdy[i]=1:
  - vld_q[i] <= source valid.
  - dat_q[i] <= source data, loaded only when source valid=1; otherwise dat_q[i] holds.
- When rdy[i]=0, stage i holds both valid and data.
- out_valid = vld_q[DEPTH-1] && !flush; out_data = dat_q[DEPTH-1].
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Latency and throughput: with no stalls, a beat accepted at edge n appears on out_valid/out_data after edge n+DEPTH-1, i.e. DEPTH cycles of latency. Throughput is 1 beat/cycle sustained.
- Bubble collapse: an empty stage always accepts from upstream even when a later stage is stalled. The chain therefore holds up to DEPTH beats under full backpressure.
- Stall stability: while out_valid && !out_ready, out_data and out_valid stay stable until the transfer.
- Ordering: strict FIFO order; no beat is lost or duplicated.
- Full chain with out_ready=1: in_ready=1, and input and output transfers occur in the same cycle.
- Flush:
  - At the next edge all vld_q become 0; dat_q hold.
  - Flush takes priority over any load.
  - While flush=1, in_ready=0 and out_valid=0, so no handshake completes in the flush cycle.
- Reset (async, any time, including mid-stream):
  - All vld_q and dat_q go to 0 immediately, so out_valid=0 and out_data=0.
  - in_ready=1 while flush=0, including while rst is asserted.
  - First edge after deassertion behaves as a normal cycle.
- in_data is don't-care when in_valid=0. No ready-to-valid combinational dependency exists on the input side.

Optional Feature:
- Macro: PIPE_OCC_EN.
- Defined:
  - occ port and register exist; reset value 0.
  - +1 on input transfer only; -1 on output transfer only; unchanged when both or neither occur.
  - Flush forces 0 at the next edge.
  - Invariant: occ equals popcount(vld_q) every cycle.
- Undefined: no occ port, no counter logic; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - PIPE_DEF_WIDTH = 32.
  - PIPE_DEF_DEPTH = 2.
  - An occupancy-width helper (clog2(DEPTH+1)) used by the top and the bench.
- One sub-module, pipe_stage:
  - Contains a single valid/data register pair with rst and flush.
  - Inputs: upstream valid/data and downstream ready.
  - Outputs: stage ready, valid and data.
- The top generates DEPTH instances of pipe_stage and stitches the rdy chain.

Test Plan:
- Reset: WIDTH=32, DEPTH=3, assert rst mid-stream with 2 beats in flight -> out_valid=0 and out_data=0 immediately, in_ready=1, occ=0; after release, no stale beat ever emerges.
- Streaming: out_ready=1, send 0,1,2,… back-to-back from edge 0 -> out_valid first high after edge 2 with data 0, then one beat per cycle in order, in_ready constantly 1.
- Backpressure: out_ready=0, push 0xA5A5A5A5, 0x1, 0x2, 0x3 -> exactly 3 accepted, in_ready=0 on the 4th, out_data holds 0xA5A5A5A5; raise out_ready -> outputs 0xA5A5A5A5, 0x1, 0x2, 0x3 with no loss or duplicate.
- Bubble collapse: out_ready=0, beat A at cycle 0, beat B at cycle 3 -> both held with in_ready=1 until the 3rd beat fills the chain; occ=2 after B.
- Flush: 3 beats resident, flush=1 for one cycle -> out_valid=0 and in_ready=0 during flush, all stages empty next cycle, occ=0, in_data offered during flush not captured.
- Full with simultaneous transfer: chain full, out_ready=1, in_valid=1 for 10 cycles -> in_ready=1 every cycle, occ stays 3, output sequence matches input delayed by 3 beats.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared defaults and helpers for the stallable pipeline chain (pipe_stage_chain).
// The occupancy-width helper sizes the optional PIPE_OCC_EN counter in the RTL and the bench.
package pipe_pkg;

  localparam int PIPE_DEF_WIDTH = 32;
  localparam int PIPE_DEF_DEPTH = 2;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data register pair: 1-cycle latency.
// Backpressure: holds its beat while full and downstream is not ready; flush beats any load.
module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             up_vld_i,
  input  logic [WIDTH-1:0] up_dat_i,
  input  logic             dn_rdy_i,
  output logic             rdy_o,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  // An empty stage always accepts, which is what collapses bubbles.
  assign rdy_o = !vld_q || dn_rdy_i;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (rdy_o) begin
      vld_d = up_vld_i;
      if (up_vld_i) dat_d = up_dat_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage valid/ready register chain, DEPTH cycles latency, holds DEPTH beats under backpressure.
// Optional occupancy counter and occ port exist only when PIPE_OCC_EN is defined.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_DEF_WIDTH,
  parameter int DEPTH = PIPE_DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_OCC_EN
  ,
  output logic [occ_w(DEPTH)-1:0] occ
`endif
);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  assign rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_vld;
    logic [WIDTH-1:0] up_dat;

    if (i == 0) begin : g_head
      assign up_vld = in_valid;
      assign up_dat = in_data;
    end else begin : g_body
      assign up_vld = vld[i-1];
      assign up_dat = dat[i-1];
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (flush),
      .up_vld_i (up_vld),
      .up_dat_i (up_dat),
      .dn_rdy_i (rdy[i+1]),
      .rdy_o    (rdy[i]),
      .vld_o    (vld[i]),
      .dat_o    (dat[i])
    );
  end

  // Masking both handshakes with flush keeps any beat from completing in the flush cycle.
  assign in_ready  = rdy[0] && !flush;
  assign out_valid = vld[DEPTH-1] && !flush;
  assign out_data  = dat[DEPTH-1];

`ifdef PIPE_OCC_EN
  localparam int OCC_W = occ_w(DEPTH);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush)                     occ_d = '0;
    else if (in_xfer && !out_xfer) occ_d = occ_q + OCC_W'(1);
    else if (out_xfer && !in_xfer) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain (WIDTH=32, DEPTH=3): directed scenarios plus random traffic
// against a beat-position model; occ is checked when PIPE_OCC_EN is defined.
module tb_pipe_stage_chain;
  import pipe_pkg::*;

  localparam int W = 32;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
`ifdef PIPE_OCC_EN
  logic [occ_w(D)-1:0] occ;
`endif

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef PIPE_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: resident beats oldest-first, each with its stage position and payload.
  int           m_pos [$];
  logic [W-1:0] m_dat [$];
  logic [W-1:0] m_last = '0;

  // Per-cycle observations for the directed literal checks.
  logic         o_vld, o_rdy, o_acc;
  logic [W-1:0] o_dat;
  logic [W-1:0] obs [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit hole_from(input int j);
    int c = 0;
    foreach (m_pos[k]) if (m_pos[k] >= j) c++;
    return c < (D - j);
  endfunction

  task automatic model_clear();
    m_pos.delete();
    m_dat.delete();
  endtask

  task automatic model_step(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    int           npos [$];
    logic [W-1:0] ndat [$];
    bit           mv [$];
    bit           acc;
    if (fl) begin
      model_clear();
      return;
    end
    acc = iv && ((m_pos.size() < D) || ordy);
    foreach (m_pos[k]) mv.push_back((m_pos[k] == D-1) ? ordy : (ordy || hole_from(m_pos[k] + 1)));
    foreach (m_pos[k]) begin
      if (m_pos[k] == D-1) begin
        if (!mv[k]) begin npos.push_back(m_pos[k]); ndat.push_back(m_dat[k]); end
      end else if (mv[k]) begin
        npos.push_back(m_pos[k] + 1);
        ndat.push_back(m_dat[k]);
        if (m_pos[k] + 1 == D-1) m_last = m_dat[k];
      end else begin
        npos.push_back(m_pos[k]);
        ndat.push_back(m_dat[k]);
      end
    end
    if (acc) begin
      npos.push_back(0);
      ndat.push_back(id);
      if (D == 1) m_last = id;
    end
    m_pos = npos;
    m_dat = ndat;
  endtask

  task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    logic e_vld, e_rdy;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    e_vld = (m_pos.size() > 0) && (m_pos[0] == D-1) && !fl;
    e_rdy = !fl && ((m_pos.size() < D) || ordy);
    chk("out_valid", out_valid, e_vld);
    chk("in_ready", in_ready, e_rdy);
    if (e_vld) chk("out_data", out_data, m_last);
`ifdef PIPE_OCC_EN
    chk("occ", occ, m_pos.size());
`endif
    o_vld = out_valid;
    o_rdy = in_ready;
    o_dat = out_data;
    o_acc = iv && in_ready;
    if (out_valid && ordy) obs.push_back(out_data);
    @(posedge clk);
    model_step(iv, id, ordy, fl);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] bp [4];
    int           idx, cnt, first;

    // Reset state.
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Streaming: first output after edge 2, i.e. observed in cycle 3.
    obs.delete();
    first = -1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(k < 8, W'(k), 1'b1, 1'b0);
      if (o_vld && first < 0) first = k;
      if (k < 8 && !o_rdy) cnt++;
    end
    chk("stream_first_cycle", first, 3);
    chk("stream_in_ready_drops", cnt, 0);
    chk("stream_count", obs.size(), 8);
    foreach (obs[k]) chk("stream_data", obs[k], W'(k));

    // Backpressure: three of four accepted, head held.
    bp[0] = 32'hA5A5A5A5; bp[1] = 32'h1; bp[2] = 32'h2; bp[3] = 32'h3;
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, bp[idx], 1'b0, 1'b0);
      if (o_acc) idx++;
    end
    chk("bp_accepted", idx, 3);
    chk("bp_4th_in_ready", o_rdy, 1'b0);
    chk("bp_held_data", o_dat, 32'hA5A5A5A5);
    obs.delete();
    for (int k = 0; k < 8; k++) begin
      cycle(idx < 4, (idx < 4) ? bp[idx] : 32'h0, 1'b1, 1'b0);
      if (o_acc) idx++;
    end
    chk("bp_out_count", obs.size(), 4);
    foreach (obs[k]) if (k < 4) chk("bp_out_data", obs[k], bp[k]);

    // Bubble collapse.
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    chk("bub_a_ready", o_rdy, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0);
    chk("bub_b_ready", o_rdy, 1'b1);
    chk("bub_model_occ", m_pos.size(), 2);
`ifdef PIPE_OCC_EN
    #1 chk("bub_occ", occ, 2);
`endif
    cycle(1'b1, 32'h33, 1'b0, 1'b0);
    chk("bub_c_ready", o_rdy, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bub_full_ready", o_rdy, 1'b0);
    chk("bub_full_head", o_dat, 32'h11);

    // Flush with three resident, data offered during flush is dropped.
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("flush_out_valid", o_vld, 1'b0);
    chk("flush_in_ready", o_rdy, 1'b0);
    obs.delete();
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("post_flush_valid", o_vld, 1'b0);
    chk("post_flush_ready", o_rdy, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("post_flush_outputs", obs.size(), 0);

    // Full chain with simultaneous in/out transfers.
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h100 + W'(k), 1'b0, 1'b0);
    obs.delete();
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 32'h103 + W'(k), 1'b1, 1'b0);
      if (o_rdy) cnt++;
    end
    chk("full_ready_cycles", cnt, 10);
    chk("full_model_occ", m_pos.size(), 3);
    for (int k = 0; k < 5; k++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("full_out_count", obs.size(), 13);
    foreach (obs[k]) chk("full_out_data", obs[k], 32'h100 + W'(k));

    // Reset mid-stream with two beats in flight.
    cycle(1'b1, 32'h55, 1'b0, 1'b0);
    cycle(1'b1, 32'h66, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_data", out_data, 32'h0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
`ifdef PIPE_OCC_EN
    chk("mid_rst_occ", occ, 0);
`endif
    model_clear();
    m_last = '0;
    @(negedge clk);
    rst = 1'b0;
    obs.delete();
    for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("mid_rst_no_stale", obs.size(), 0);

    // Random traffic.
    for (int k = 0; k < 1500; k++)
      cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 25) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
